// File: rtl/hazard_scoreboard_unit.sv
// Load-use scoreboard plus branch flush sequencer for the 5-stage pipeline.
// Optional perf counters are built when HAZARD_PERF_EN is defined.
module hazard_scoreboard_unit #(
  parameter int REG_AW    = 5,
  parameter int LOAD_LAT  = 1,
  parameter int FLUSH_CYC = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic              id_rs_use_i,
  input  logic              id_rt_use_i,
  input  logic              id_memread_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic              branch_i,
  output logic              branch_o,
  output logic              stall_o,
  output logic              flush_o,
  output logic              busy_o
`ifdef HAZARD_PERF_EN
  ,
  output logic [15:0]       perf_stall_o,
  output logic [15:0]       perf_flush_o
`endif
);

  localparam int NUM_REGS = 2**REG_AW;
  localparam int CW = $clog2(LOAD_LAT + 1);
  localparam logic [CW-1:0] LAT_V = CW'(LOAD_LAT);
  localparam logic [1:0] FLUSH_INIT = 2'(FLUSH_CYC - 1);

  logic [CW-1:0]       pend_q [NUM_REGS];
  logic [CW-1:0]       pend_d [NUM_REGS];
  logic [NUM_REGS-1:0] pend_nz;
  logic [1:0]          flush_cnt_q, flush_cnt_d;
  logic                flush_act, haz, issue, load_wr;
  logic                rs_haz, rt_haz;

  assign branch_o  = branch_i;
  assign flush_act = branch_i | (flush_cnt_q != 2'd0);
  assign flush_o   = flush_act;

  assign rs_haz  = id_rs_use_i & (id_rs_i != '0) & (pend_q[id_rs_i] != '0);
  assign rt_haz  = id_rt_use_i & (id_rt_i != '0) & (pend_q[id_rt_i] != '0);
  assign haz     = id_valid_i & (rs_haz | rt_haz);
  assign stall_o = haz & ~flush_act;
  assign issue   = id_valid_i & ~stall_o & ~flush_act;
  assign load_wr = issue & id_memread_i & (id_rd_i != '0);

  // busy_o depends only on registered state, never on the ID inputs
  assign busy_o = |pend_nz;

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      pend_nz[i] = (pend_q[i] != '0);
      pend_d[i]  = pend_q[i];
      if (i != 0) begin
        if (load_wr && (id_rd_i == REG_AW'(i))) begin
          pend_d[i] = LAT_V;
        end else if (pend_q[i] != '0) begin
          pend_d[i] = pend_q[i] - CW'(1);
        end
      end
    end
  end

  always_comb begin
    flush_cnt_d = flush_cnt_q;
    if (branch_i) begin
      flush_cnt_d = FLUSH_INIT;
    end else if (flush_cnt_q != 2'd0) begin
      flush_cnt_d = flush_cnt_q - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        pend_q[i] <= '0;
      end
      flush_cnt_q <= 2'd0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        pend_q[i] <= pend_d[i];
      end
      flush_cnt_q <= flush_cnt_d;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [15:0] perf_stall_q, perf_stall_d;
  logic [15:0] perf_flush_q, perf_flush_d;

  // Both counters saturate rather than wrap
  always_comb begin
    perf_stall_d = perf_stall_q;
    perf_flush_d = perf_flush_q;
    if (stall_o && (perf_stall_q != 16'hFFFF)) begin
      perf_stall_d = perf_stall_q + 16'd1;
    end
    if (flush_o && (perf_flush_q != 16'hFFFF)) begin
      perf_flush_d = perf_flush_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_q <= 16'd0;
      perf_flush_q <= 16'd0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign perf_stall_o = perf_stall_q;
  assign perf_flush_o = perf_flush_q;
`endif

endmodule
